// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Imported by the arbiter core and its lane formatter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MA_IDLE  = 2'd0,
        MA_ISSUE = 2'd1,
        MA_WAIT  = 2'd2,
        MA_RESP  = 2'd3
    } ma_state_t;

    typedef enum logic {
        MA_IF = 1'b0,
        MA_D  = 1'b1
    } ma_id_t;

    localparam logic [3:0] WE_WORD = 4'b1111;
    localparam logic [3:0] WE_NONE = 4'b0000;

    // Byte accesses never fault; word accesses must be 4-byte aligned.
    function automatic logic is_misaligned(input logic is_byte, input logic [1:0] lane);
        return !is_byte && (lane != 2'b00);
    endfunction

endpackage

// File: rtl/mem_arbiter_lane_fmt.sv
// Byte-lane steering for stores and byte select / sign extension for loads.
// Purely combinational; lane is the low two bits of the registered address.
module mem_lane_fmt
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic        is_byte,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  st_we,
    output logic [31:0] st_wdata,
    output logic [31:0] ld_data
);

    logic [7:0] ld_byte;

    always_comb begin
        st_we    = WE_WORD;
        st_wdata = st_data;
        ld_data  = ld_word;
        ld_byte  = ld_word[7:0];

        case (lane)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase

        if (is_byte) begin
            st_we    = 4'b0001 << lane;
            st_wdata = {4{st_data[7:0]}};
            ld_data  = {{24{ld_byte[7]}}, ld_byte};
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between
// instruction fetch (IF) and data load/store (D) requesters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// MA_IDLE  | sample requests, register winner and its access fields
// MA_ISSUE | grant pulse; RAM strobe, or error pulse if misaligned
// MA_WAIT  | RD_LAT-1 cycles of read latency (down-counter)
// MA_RESP  | read data valid to the winner, formatted from ram_rdata
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_err,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_err,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              busy
);

    localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

    ma_state_t         state;
    ma_state_t         state_nxt;
    ma_id_t            winner;
    ma_id_t            last_gnt;
    ma_id_t            pick;
    logic              pick_valid;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_we;
    logic              cur_byte;
    logic [31:0]       cur_wdata;
    logic [2:0]        wait_cnt;
    logic              cur_err;
    logic [3:0]        lane_we;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;

    // Contention goes to whoever was not granted last.
    always_comb begin
        pick_valid = if_req | d_req;
        pick       = MA_IF;
        if (if_req && d_req) begin
            pick = (last_gnt == MA_IF) ? MA_D : MA_IF;
        end else if (d_req) begin
            pick = MA_D;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= MA_IDLE;
            winner    <= MA_IF;
            last_gnt  <= MA_D;
            cur_addr  <= '0;
            cur_we    <= 1'b0;
            cur_byte  <= 1'b0;
            cur_wdata <= '0;
            wait_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == MA_IDLE && pick_valid) begin
                winner <= pick;
                if (pick == MA_IF) begin
                    cur_addr  <= if_addr;
                    cur_we    <= 1'b0;
                    cur_byte  <= 1'b0;
                    cur_wdata <= '0;
                end else begin
                    cur_addr  <= d_addr;
                    cur_we    <= d_we;
                    cur_byte  <= d_byte;
                    cur_wdata <= d_wdata;
                end
            end
            if (state == MA_ISSUE) begin
                last_gnt <= winner;
                wait_cnt <= WAIT_INIT;
            end else if (state == MA_WAIT) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
        end
    end

    assign cur_err = is_misaligned(cur_byte, cur_addr[1:0]);

    always_comb begin
        state_nxt = state;
        case (state)
            MA_IDLE: begin
                if (pick_valid) state_nxt = MA_ISSUE;
            end
            MA_ISSUE: begin
                if (cur_err || cur_we) state_nxt = MA_IDLE;
                else if (RD_LAT > 1)   state_nxt = MA_WAIT;
                else                   state_nxt = MA_RESP;
            end
            MA_WAIT: begin
                if (wait_cnt == 3'd1) state_nxt = MA_RESP;
            end
            MA_RESP: state_nxt = MA_IDLE;
            default: state_nxt = MA_IDLE;
        endcase
    end

    // All strobes decode registered state and winner only.
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_err    = 1'b0;
        d_err     = 1'b0;
        ram_en    = 1'b0;
        ram_we    = WE_NONE;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        busy      = (state != MA_IDLE);

        if (state == MA_ISSUE) begin
            if_gnt = (winner == MA_IF);
            d_gnt  = (winner == MA_D);
            if_err = (winner == MA_IF) && cur_err;
            d_err  = (winner == MA_D) && cur_err;
            ram_en = !cur_err;
            if (!cur_err && cur_we) ram_we = lane_we;
        end

        if (state == MA_RESP) begin
            if (winner == MA_IF) begin
                if_rvalid = 1'b1;
                if_rdata  = ram_rdata;
            end else begin
                d_rvalid = 1'b1;
                d_rdata  = lane_rdata;
            end
        end
    end

    assign ram_addr  = cur_addr[ADDR_W-1:2];
    assign ram_wdata = lane_wdata;

    mem_lane_fmt u_lane_fmt (
        .lane     (cur_addr[1:0]),
        .is_byte  (cur_byte),
        .st_data  (cur_wdata),
        .ld_word  (ram_rdata),
        .st_we    (lane_we),
        .st_wdata (lane_wdata),
        .ld_data  (lane_rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: three instances (RD_LAT 1, 3, 4), each
// with its own behavioural RAM, checked against a transaction-level reference.
module tb_mem_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset     [N];
    logic        if_req    [N];
    logic [31:0] if_addr   [N];
    logic        if_gnt    [N];
    logic        if_err    [N];
    logic        if_rvalid [N];
    logic [31:0] if_rdata  [N];
    logic        d_req     [N];
    logic        d_we      [N];
    logic        d_byte    [N];
    logic [31:0] d_addr    [N];
    logic [31:0] d_wdata   [N];
    logic        d_gnt     [N];
    logic        d_err     [N];
    logic        d_rvalid  [N];
    logic [31:0] d_rdata   [N];
    logic        ram_en    [N];
    logic [3:0]  ram_we    [N];
    logic [29:0] ram_addr  [N];
    logic [31:0] ram_wdata [N];
    logic [31:0] ram_rdata [N];
    logic        busy      [N];

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem  [N][256];
    int          last_gnt [N];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h0101_0107) ^ 32'h9E37_79B9;
    endfunction

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        logic [31:0] mem  [256];
        logic [31:0] pipe [8];

        mem_arbiter #(.ADDR_W(32), .RD_LAT(LAT)) u_dut (
            .clk       (clk),
            .reset     (reset[g]),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_gnt    (if_gnt[g]),
            .if_err    (if_err[g]),
            .if_rvalid (if_rvalid[g]),
            .if_rdata  (if_rdata[g]),
            .d_req     (d_req[g]),
            .d_we      (d_we[g]),
            .d_byte    (d_byte[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_gnt     (d_gnt[g]),
            .d_err     (d_err[g]),
            .d_rvalid  (d_rvalid[g]),
            .d_rdata   (d_rdata[g]),
            .ram_en    (ram_en[g]),
            .ram_we    (ram_we[g]),
            .ram_addr  (ram_addr[g]),
            .ram_wdata (ram_wdata[g]),
            .ram_rdata (ram_rdata[g]),
            .busy      (busy[g])
        );

        initial begin
            for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        end

        // RAM returns read data LAT cycles after the enable cycle; junk otherwise.
        always @(posedge clk) begin
            pipe[0] <= (ram_en[g] && ram_we[g] == 4'b0000) ? mem[ram_addr[g][7:0]] : $urandom;
            for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
            if (ram_en[g]) begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[g][b]) mem[ram_addr[g][7:0]][8*b +: 8] = ram_wdata[g][8*b +: 8];
            end
        end

        assign ram_rdata[g] = pipe[LAT-1];
    end

    task automatic chk(input int k, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL dut%0d %s: observed=%h expected=%h", k, tag, obs, exp);
        end
    endtask

    task automatic issue_if(input int k, input logic [31:0] a);
        if_addr[k] = a;
        if_req[k]  = 1'b1;
    endtask

    task automatic issue_d(input int k, input logic we, input logic byt,
                           input logic [31:0] a, input logic [31:0] wd);
        d_we[k]    = we;
        d_byte[k]  = byt;
        d_addr[k]  = a;
        d_wdata[k] = wd;
        d_req[k]   = 1'b1;
    endtask

    // Called in the IDLE cycle in which the winner's request is sampled; returns
    // (sampling point) in the next IDLE cycle after the transaction completes.
    task automatic expect_txn(input int k, input int who, input logic we, input logic byt,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic hold);
        int          lat;
        int          span;
        int          w;
        int          lane;
        logic        err;
        logic        rd;
        logic [31:0] word;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        logic [3:0]  exp_we;
        lat    = lat_of(k);
        err    = !byt && (addr[1:0] != 2'b00);
        rd     = !err && !we;
        span   = rd ? lat + 1 : 1;
        w      = int'(addr[9:2]);
        lane   = int'(addr[1:0]);
        word   = ref_mem[k][w];
        exp_rd = byt ? sext8(8'(word >> (8 * lane))) : word;
        exp_we = byt ? 4'(1 << lane) : 4'hF;
        exp_wd = byt ? {4{wdata[7:0]}} : wdata;
        if (we && !err) begin
            if (byt) ref_mem[k][w][8*lane +: 8] = wdata[7:0];
            else     ref_mem[k][w] = wdata;
        end
        for (int c = 1; c <= span + 1; c++) begin
            @(posedge clk); #1;
            if (c == 1 && !hold) begin
                if (who == 0) if_req[k] = 1'b0;
                else          d_req[k]  = 1'b0;
            end
            chk(k, "if_gnt",    32'(if_gnt[k]),    32'(c == 1 && who == 0));
            chk(k, "d_gnt",     32'(d_gnt[k]),     32'(c == 1 && who == 1));
            chk(k, "if_err",    32'(if_err[k]),    32'(c == 1 && who == 0 && err));
            chk(k, "d_err",     32'(d_err[k]),     32'(c == 1 && who == 1 && err));
            chk(k, "ram_en",    32'(ram_en[k]),    32'(c == 1 && !err));
            chk(k, "ram_we",    32'(ram_we[k]),    (c == 1 && we && !err) ? 32'(exp_we) : 32'h0);
            if (c == 1 && !err) chk(k, "ram_addr", 32'(ram_addr[k]), {2'b00, addr[31:2]});
            if (c == 1 && we && !err) chk(k, "ram_wdata", ram_wdata[k], exp_wd);
            chk(k, "if_rvalid", 32'(if_rvalid[k]), 32'(rd && c == lat + 1 && who == 0));
            chk(k, "if_rdata",  if_rdata[k],       (rd && c == lat + 1 && who == 0) ? exp_rd : 32'h0);
            chk(k, "d_rvalid",  32'(d_rvalid[k]),  32'(rd && c == lat + 1 && who == 1));
            chk(k, "d_rdata",   d_rdata[k],        (rd && c == lat + 1 && who == 1) ? exp_rd : 32'h0);
            chk(k, "busy",      32'(busy[k]),      32'(c <= span));
        end
        last_gnt[k] = who;
    endtask

    task automatic do_if(input int k, input logic [31:0] a);
        issue_if(k, a);
        expect_txn(k, 0, 1'b0, 1'b0, a, 32'h0, 1'b0);
    endtask

    task automatic do_d(input int k, input logic we, input logic byt,
                        input logic [31:0] a, input logic [31:0] wd);
        issue_d(k, we, byt, a, wd);
        expect_txn(k, 1, we, byt, a, wd, 1'b0);
    endtask

    task automatic do_pair(input int k, input logic [31:0] ia, input logic we, input logic byt,
                           input logic [31:0] da, input logic [31:0] wd);
        issue_if(k, ia);
        issue_d(k, we, byt, da, wd);
        if (last_gnt[k] == 0) begin
            expect_txn(k, 1, we, byt, da, wd, 1'b0);
            expect_txn(k, 0, 1'b0, 1'b0, ia, 32'h0, 1'b0);
        end else begin
            expect_txn(k, 0, 1'b0, 1'b0, ia, 32'h0, 1'b0);
            expect_txn(k, 1, we, byt, da, wd, 1'b0);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        return ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_003F) : $urandom;
    endfunction

    int          kind;
    logic        r_we;
    logic        r_byt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_wd;

    initial begin
        for (int k = 0; k < N; k++) begin
            reset[k]   = 1'b0;
            if_req[k]  = 1'b0;
            if_addr[k] = '0;
            d_req[k]   = 1'b0;
            d_we[k]    = 1'b0;
            d_byte[k]  = 1'b0;
            d_addr[k]  = '0;
            d_wdata[k] = '0;
            last_gnt[k] = 1;
            for (int i = 0; i < 256; i++) ref_mem[k][i] = init_word(i);
        end

        #2;
        for (int k = 0; k < N; k++) begin
            chk(k, "rst_busy",   32'(busy[k]),   32'h0);
            chk(k, "rst_ram_en", 32'(ram_en[k]), 32'h0);
            chk(k, "rst_ram_we", 32'(ram_we[k]), 32'h0);
            chk(k, "rst_gnt",    32'({if_gnt[k], d_gnt[k]}), 32'h0);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) reset[k] = 1'b1;

        // RD_LAT = 1 directed sequence
        do_d(0, 1'b1, 1'b0, 32'h0000_0010, 32'h3C01_1234);
        do_if(0, 32'h0000_0010);
        do_d(0, 1'b1, 1'b0, 32'h0000_0100, 32'h80FF_0012);
        do_d(0, 1'b0, 1'b1, 32'h0000_0103, 32'h0);
        do_d(0, 1'b0, 1'b1, 32'h0000_0100, 32'h0);
        do_d(0, 1'b1, 1'b1, 32'h0000_0022, 32'hAABB_CC5A);
        do_d(0, 1'b0, 1'b0, 32'h0000_0006, 32'h0);
        do_if(0, 32'h0000_0012);
        do_d(0, 1'b0, 1'b0, 32'h0000_0020, 32'h0);

        // RD_LAT = 3: both requests held continuously from reset
        issue_if(1, 32'h0000_0010);
        issue_d(1, 1'b0, 1'b0, 32'h0000_0024, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (last_gnt[1] == 0) expect_txn(1, 1, 1'b0, 1'b0, 32'h0000_0024, 32'h0, 1'b1);
            else                  expect_txn(1, 0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b1);
        end
        if_req[1] = 1'b0;
        d_req[1]  = 1'b0;

        // RD_LAT = 4: reset during the WAIT of a fetch
        issue_if(2, 32'h0000_0030);
        @(posedge clk); #1;
        if_req[2] = 1'b0;
        chk(2, "abort_gnt", 32'(if_gnt[2]), 32'h1);
        @(posedge clk); #1;
        chk(2, "abort_busy", 32'(busy[2]), 32'h1);
        reset[2] = 1'b0;
        #1;
        chk(2, "rst_if_gnt",    32'(if_gnt[2]),    32'h0);
        chk(2, "rst_d_gnt",     32'(d_gnt[2]),     32'h0);
        chk(2, "rst_if_err",    32'(if_err[2]),    32'h0);
        chk(2, "rst_d_err",     32'(d_err[2]),     32'h0);
        chk(2, "rst_if_rvalid", 32'(if_rvalid[2]), 32'h0);
        chk(2, "rst_d_rvalid",  32'(d_rvalid[2]),  32'h0);
        chk(2, "rst_if_rdata",  if_rdata[2],       32'h0);
        chk(2, "rst_d_rdata",   d_rdata[2],        32'h0);
        chk(2, "rst_en",        32'(ram_en[2]),    32'h0);
        chk(2, "rst_we",        32'(ram_we[2]),    32'h0);
        chk(2, "rst_addr",      32'(ram_addr[2]),  32'h0);
        chk(2, "rst_wdata",     ram_wdata[2],      32'h0);
        chk(2, "rst_busy2",     32'(busy[2]),      32'h0);
        @(posedge clk); #1;
        reset[2] = 1'b1;
        last_gnt[2] = 1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk(2, "post_rst_rvalid", 32'(if_rvalid[2]), 32'h0);
            chk(2, "post_rst_busy",   32'(busy[2]),      32'h0);
        end
        do_pair(2, 32'h0000_0034, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
        do_d(2, 1'b0, 1'b0, 32'h0000_0044, 32'h0);

        // Randomized traffic on every instance
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 30; i++) begin
                kind  = $urandom_range(0, 4);
                r_we  = 1'($urandom_range(0, 1));
                r_byt = 1'($urandom_range(0, 1));
                r_a   = rand_addr();
                r_b   = rand_addr();
                r_wd  = $urandom;
                if (kind <= 1)      do_d(k, r_we, r_byt, r_a, r_wd);
                else if (kind == 2) do_d(k, 1'b0, r_byt, r_a, 32'h0);
                else if (kind == 3) do_if(k, r_b);
                else                do_pair(k, r_b, r_we, r_byt, r_a, r_wd);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous RAM between two requesters: instruction fetch (IF port) and data load/store (D port).
- Sits between the multi-cycle CPU datapath (IR fetch, byte/word access controller) and the unified memory.
- Round-robin arbitration, request/grant handshake, fixed-latency read response, byte-lane steering for byte load/store, misalignment error reporting.

Parameters:
- ADDR_W, 32, byte-address width of requester ports.
- RD_LAT, 1, cycles from RAM enable to valid ram_rdata; legal values 1..7.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  one-cycle grant pulse.
- if_err  out  1  one-cycle pulse with if_gnt: misaligned fetch.
- if_rvalid  out  1  one-cycle read-data-valid pulse.
- if_rdata  out  32  fetched word.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_byte  in  1  1 = byte access, 0 = word access.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data; byte store uses bits 7:0.
- d_gnt  out  1  one-cycle grant pulse.
- d_err  out  1  one-cycle pulse with d_gnt: misaligned word access.
- d_rvalid  out  1  one-cycle load-data-valid pulse.
- d_rdata  out  32  load data; byte loads sign-extended.
- ram_en  out  1  RAM access strobe.
- ram_we  out  4  byte write enables; bit n = bits 8n+7:8n.
- ram_addr  out  ADDR_W-2  word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid RD_LAT cycles after ram_en.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset:
  - All outputs 0; state IDLE.
  - Round-robin pointer favours IF.
  - Assertion mid-operation aborts immediately; the in-flight response is never delivered; RAM write strobes drop at once.
- States:
  - IDLE: sample if_req/d_req.
    - Exactly one requester active: that requester wins.
    - Both active: the requester not granted last wins.
    - Winner's address, we, byte and wdata are registered → ISSUE.
    - No request: stay in IDLE.
  - ISSUE, one cycle:
    - Winner's gnt = 1.
    - If the request is misaligned: err = 1, ram_en = 0 → IDLE.
    - Otherwise ram_en = 1.
    - Store → IDLE, no response.
    - Load/fetch → WAIT if RD_LAT > 1, else → RESP.
    - Round-robin pointer updates to the winner, including on error.
  - WAIT: RD_LAT-1 cycles, counted by a 3-bit down-counter → RESP.
  - RESP, one cycle:
    - Winner's rvalid = 1; rdata formatted combinationally from ram_rdata → IDLE.
- Latency: request seen in IDLE at cycle t.
  - gnt and ram_en at t+1.
  - rvalid at t+1+RD_LAT.
  - Next arbitration at t+2+RD_LAT for reads, t+2 for stores.
- Misalignment:
  - Error condition: word access with addr[1:0] != 0. All fetches are word accesses; byte accesses never fault.
  - On error: no RAM access, no rvalid.
- Byte lanes (little-endian lanes, lane = addr[1:0]):
  - Byte store: ram_we = 4'b0001 << lane; ram_wdata = d_wdata[7:0] replicated into all four lanes.
  - Word store: ram_we = 4'b1111; ram_wdata = d_wdata.
  - Byte load: d_rdata = sign-extended ram_rdata[8*lane+7 : 8*lane].
  - Word load: d_rdata = ram_rdata.
  - Lane is taken from the registered address.
- Read-data outputs are 0 when the corresponding rvalid is 0.
- Fetch path ignores d_we/d_byte; fetches are always word reads.
- ram_addr = registered addr[ADDR_W-1:2]; valid only while ram_en = 1, otherwise held.
- Request rules:
  - A req dropped before grant is treated as withdrawn; nothing is latched.
  - A req still high in the IDLE cycle after completion is a new request; requesters must drop req the cycle after gnt.
- Outputs if_gnt, d_gnt, if_err, d_err, ram_en, ram_we, if_rvalid, d_rvalid are state-decoded from registered state and registered winner; no combinational path from req to any output.

Decomposition:
- Shared package/header:
  - State encodings MA_IDLE, MA_ISSUE, MA_WAIT, MA_RESP.
  - Requester IDs MA_IF, MA_D.
  - Byte-enable constants WE_WORD, WE_NONE.
- One sub-module, mem_lane_fmt (combinational): store lane steering (ram_we, ram_wdata) and load byte select/sign-extension.

Test Plan:
- Single fetch, RD_LAT=1, if_addr=0x0000_0010, ram_rdata=0x3C01_1234 → if_gnt at t+1, ram_addr=0x4, ram_en=1, ram_we=0; if_rvalid at t+2 with if_rdata=0x3C01_1234; busy high t+1..t+2.
- Byte load d_addr=0x0000_0103, ram_rdata=0x80FF_0012 → lane 3, d_rdata=0xFFFF_FF80. Repeat with d_addr=0x0000_0100 → d_rdata=0x0000_0012.
- Byte store d_addr=0x0000_0022, d_wdata=0xAABB_CC5A → ram_we=4'b0100, ram_wdata=0x5A5A_5A5A, ram_addr=0x8, no d_rvalid, busy low at t+2.
- if_req and d_req both held continuously with RD_LAT=3 → grants alternate IF, D, IF, D from reset; each read gets rvalid exactly 3 cycles after its gnt.
- Word load d_addr=0x0000_0006 → d_gnt and d_err together at t+1, ram_en never asserted, no d_rvalid, IDLE at t+2.
- reset low during WAIT of a fetch (RD_LAT=4) → all outputs 0 immediately; after release, no if_rvalid; a fresh d_req is granted first only when if_req is idle, otherwise IF wins (pointer reset).
